sram_pattern_gen: RTL

SRAM_PATTERN_GEN -- requirements
Module: sram_pattern_gen

---
 rtl/sram_pattern_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_pattern_gen.sv
// SRAM pattern generator: writes a selected data pattern to every address, reads it back,
// and presents the expected word aligned with the SRAM read data for an external comparator.
module sram_pattern_gen #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        pattern_sel_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic              sram_we_o,
    output logic              sram_re_o,
    output logic [31:0]       exp_data_o,
    output logic              exp_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_s;
    logic [1:0]        sel_r;
    logic [1:0]        sel_s;
    logic [1:0]        drain_cnt_r;
    logic [1:0]        drain_cnt_s;
    logic              pipe_v_r [RD_LAT];
    logic [31:0]       pipe_d_r [RD_LAT];

    function automatic logic [31:0] pattern(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
        logic [31:0] word;
        case (sel)
            2'b00:   word = 32'h0000_0000;
            2'b01:   word = 32'hFFFF_FFFF;
            2'b10:   word = addr[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            2'b11:   word = 32'(addr);
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Next-state, next-address and latched pattern selection
    always_comb begin
        state_s     = state_r;
        addr_s      = sram_addr_o;
        sel_s       = sel_r;
        drain_cnt_s = drain_cnt_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = WRITE;
                    addr_s  = {ADDR_W{1'b0}};
                    sel_s   = pattern_sel_i;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (sram_addr_o == LAST_ADDR) begin
                    state_s = READ;
                    addr_s  = {ADDR_W{1'b0}};
                end else begin
                    addr_s = sram_addr_o + ADDR_W'(1);
                end
            end
            READ: begin
                if (sram_addr_o == LAST_ADDR) begin
                    state_s     = DRAIN;
                    addr_s      = {ADDR_W{1'b0}};
                    drain_cnt_s = 2'd0;
                end else begin
                    addr_s = sram_addr_o + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_s = DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + 2'd1;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= 2'b00;
            drain_cnt_r  <= 2'd0;
            sram_addr_o  <= {ADDR_W{1'b0}};
            sram_wdata_o <= 32'h0000_0000;
            sram_we_o    <= 1'b0;
            sram_re_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            drain_cnt_r  <= drain_cnt_s;
            sram_addr_o  <= addr_s;
            sram_wdata_o <= (state_s == WRITE) ? pattern(sel_s, addr_s) : 32'h0000_0000;
            sram_we_o    <= (state_s == WRITE);
            sram_re_o    <= (state_s == READ);
            busy_o       <= (state_s == WRITE) || (state_s == READ) || (state_s == DRAIN);
            done_o       <= (state_s == DONE);
        end
    end

    // Expected-data delay line matching the SRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_d_r[i] <= 32'h0000_0000;
            end
        end else begin
            pipe_v_r[0] <= sram_re_o;
            pipe_d_r[0] <= sram_re_o ? pattern(sel_r, sram_addr_o) : 32'h0000_0000;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_d_r[i] <= pipe_d_r[i-1];
            end
        end
    end

    assign exp_valid_o = pipe_v_r[RD_LAT-1];
    assign exp_data_o  = pipe_d_r[RD_LAT-1];

endmodule
